can_sync_fifo: RTL and testbench
================================

// Module: can_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO for CAN frame buffering. It sits between the
//  bit-stream engine and the host register interface, one instance for TX and
//  one for RX. It adds the following over the fixed 128x? FIFO:
//  - configurable width and depth
//  - first-word-fall-through (FWFT) mode
//  - fill level with almost-full / almost-empty thresholds
//  - synchronous flush
//  - sticky error flags
// PARAMETERS
//  DATA_W    128  word width (one CAN frame record)
//  DEPTH     16   entries; power of two, >= 2
//  FWFT      0    0: registered read, data 1 cycle after pop; 1: head word always on bus
//  AF_LEVEL  14   o_almost_full when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2    o_almost_empty when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  i_sys_clk       in   1        system clock, all logic on rising edge
//  i_reset_n       in   1        asynchronous, active-low reset
//  i_flush         in   1        synchronous clear of contents
//  i_wr_en         in   1        push request
//  i_fifo_w_data   in   DATA_W   push data
//  i_r_en          in   1        pop request
//  o_fifo_r_data   out  DATA_W   read data
//  o_empty         out  1        count == 0
//  o_full          out  1        count == DEPTH
//  o_almost_empty  out  1        count <= AE_LEVEL
//  o_almost_full   out  1        count >= AF_LEVEL
//  o_count         out  CW       fill level, CW = $clog2(DEPTH+1)
//  o_overflow      out  1        1-cycle pulse: write rejected
//  o_underflow     out  1        1-cycle pulse: read rejected
//  o_err_sticky    out  2        {ovf,unf} sticky; cleared only by reset or i_flush
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - pointers, count = 0; o_empty = 1, o_almost_empty = 1
//    - o_full, o_almost_full, o_overflow, o_underflow = 0; o_err_sticky = 0
//    - o_fifo_r_data = 0
//  - Read accept: rd_ok = i_r_en & !o_empty.
//  - Write accept: wr_ok = i_wr_en & (!o_full | rd_ok). Full with simultaneous
//    pop accepts both; count is unchanged.
//  - Empty with simultaneous rd+wr: the write is accepted, the read is rejected
//    (underflow). The word is not bypassed to the output.
//  - count_next = count + wr_ok - rd_ok. All status flags are registered from
//    count_next, so they are valid in the cycle after the edge that changed the count.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
//  - FWFT=0: on rd_ok, o_fifo_r_data loads mem[rd_ptr] at that edge (latency 1).
//    It holds its value otherwise, including when empty.
//  - FWFT=1: o_fifo_r_data = mem[rd_ptr] whenever !o_empty, 0 when empty.
//    - A word written into an empty FIFO appears 1 cycle after the write edge.
//    - rd_ok advances to the next word in the same cycle that o_empty updates.
//  - Rejected write: memory and pointers are untouched. o_overflow = 1 for the
//    next cycle; o_err_sticky[1] is set.
//  - Rejected read: pointers and data are untouched. o_underflow = 1 for the
//    next cycle; o_err_sticky[0] is set.
//  - i_flush has priority over rd/wr in the same cycle:
//    - pointers and count go to 0; concurrent write and read are discarded
//    - no overflow/underflow pulse is raised; o_err_sticky is cleared
//    - o_fifo_r_data is zeroed
//  - Reset mid-operation drops all contents immediately. There is no partial-write
//    hazard because memory writes are gated by wr_ok.
//  - Memory contents are not reset; only pointers and outputs are.
// STRUCTURE
//  - can_pkg holds shared definitions used by the controller and this block:
//    - localparam CAN_FRAME_W = 128
//    - typedef logic [CAN_FRAME_W-1:0] can_frame_t
//    - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e
//  - Sub-module can_fifo_mem: DEPTH x DATA_W dual-port array with one synchronous
//    write port and one asynchronous read port, inferable as distributed RAM.
//  - Pointer, count, flag and error logic stay in the top module.
// TESTING  (DEPTH=4, DATA_W=128, AF_LEVEL=3, AE_LEVEL=1 unless noted)
//  1. Reset, then 4 writes of 0x1, 0x10..10, 0xFF..FF, 0x11..11.
//     -> o_count 1,2,3,4; o_almost_full at 3; o_full at 4; no overflow.
//     -> A 5th write raises o_overflow for 1 cycle, o_err_sticky = 2'b10, count stays 4.
//  2. FWFT=0, from the full state of test 1, 4 pops.
//     -> data 0x1, 0x10..10, 0xFF..FF, 0x11..11, each 1 cycle after its pop.
//     -> o_empty after the 4th pop; a 5th pop raises o_underflow, o_err_sticky = 2'b11.
//  3. Full plus simultaneous rd+wr of 0xAA..AA.
//     -> both accepted, count stays 4, no overflow.
//     -> Draining returns 0xAA..AA last.
//  4. FWFT=1, write 0x5 into an empty FIFO.
//     -> o_fifo_r_data = 0x5 and o_empty = 0 one cycle later without a pop.
//     -> Pop -> o_empty = 1, data = 0.
//  5. Write 3 words, then i_flush together with i_wr_en.
//     -> next cycle count = 0, o_empty = 1, o_err_sticky = 0, no pulses.
//     -> Write discarded; a subsequent pop underflows.
//  6. Write 6 and read 6 across the wrap, then deassert i_reset_n mid-burst.
//     -> FIFO order is preserved across the wrap.
//     -> All outputs reach their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions used by the controller and the frame FIFOs.
package can_pkg;

  localparam int unsigned CAN_FRAME_W = 128;

  typedef logic [CAN_FRAME_W-1:0] can_frame_t;

  typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e;

endpackage

// File: rtl/can_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// No reset on the array so it can map onto distributed RAM.
module can_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: only accepted pushes reach the array.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/can_sync_fifo.sv
// Single-clock CAN frame FIFO with optional first-word-fall-through, fill level,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module can_sync_fifo
  import can_pkg::*;
#(
  parameter int unsigned DATA_W   = CAN_FRAME_W,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_fifo_w_data,
  input  logic              i_r_en,
  output logic [DATA_W-1:0] o_fifo_r_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic [CW-1:0]     o_count,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic [1:0]        o_err_sticky
);

  localparam fifo_mode_e Mode = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_empty, r_full, r_almost_empty, r_almost_full;
  logic              r_overflow, r_underflow;
  logic [1:0]        r_err_sticky;

  logic              w_rd_ok, w_wr_ok;
  logic [CW-1:0]     w_count_next;
  logic [DATA_W-1:0] w_mem_rdata;

  // Accept decisions: a pop frees a slot, so full + pop still takes the write.
  // Empty + push + pop rejects the pop; the new word is never bypassed.
  assign w_rd_ok = i_r_en & ~r_empty;
  assign w_wr_ok = i_wr_en & (~r_full | w_rd_ok);

  // Next fill level; flush overrides any concurrent push/pop.
  always_comb begin
    w_count_next = r_count;
    if (i_flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    end
  end

  // Pointers and count.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Status flags registered from the next count so they track o_count exactly.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
    end else begin
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == CW'(DEPTH));
      r_almost_empty <= (w_count_next <= CW'(AE_LEVEL));
      r_almost_full  <= (w_count_next >= CW'(AF_LEVEL));
    end
  end

  // Error pulses and sticky flags; flush suppresses pulses and clears sticky bits.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_err_sticky <= 2'b00;
    end else if (i_flush) begin
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_err_sticky <= 2'b00;
    end else begin
      r_overflow   <= i_wr_en & ~w_wr_ok;
      r_underflow  <= i_r_en & ~w_rd_ok;
      r_err_sticky <= r_err_sticky | {i_wr_en & ~w_wr_ok, i_r_en & ~w_rd_ok};
    end
  end

  can_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk   (i_sys_clk),
    .i_we    (w_wr_ok & ~i_flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_fifo_w_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  if (Mode == FIFO_FWFT) begin : g_fwft
    // Head word is always presented; zero while empty (also covers reset/flush).
    assign o_fifo_r_data = r_empty ? '0 : w_mem_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] r_rdata;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_rdata <= '0;
      end else if (i_flush) begin
        r_rdata <= '0;
      end else if (w_rd_ok) begin
        r_rdata <= w_mem_rdata;
      end
    end

    assign o_fifo_r_data = r_rdata;
  end

  assign o_empty        = r_empty;
  assign o_full         = r_full;
  assign o_almost_empty = r_almost_empty;
  assign o_almost_full  = r_almost_full;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_can_sync_fifo.sv
// Directed bench: registered-read instance (u_std) and FWFT instance (u_fwft),
// both DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_can_sync_fifo;

  localparam int W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Registered-read instance
  logic         s_flush = 0, s_wr = 0, s_rd = 0;
  logic [W-1:0] s_wd = '0, s_rdat;
  logic         s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic [2:0]   s_cnt;
  logic [1:0]   s_err;

  // FWFT instance
  logic         f_flush = 0, f_wr = 0, f_rd = 0;
  logic [W-1:0] f_wd = '0, f_rdat;
  logic         f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [2:0]   f_cnt;
  logic [1:0]   f_err;

  int n_cmp = 0;
  int n_err = 0;

  can_sync_fifo #(.DATA_W(W), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_std (
    .i_sys_clk(clk), .i_reset_n(rst_n), .i_flush(s_flush), .i_wr_en(s_wr),
    .i_fifo_w_data(s_wd), .i_r_en(s_rd), .o_fifo_r_data(s_rdat), .o_empty(s_empty),
    .o_full(s_full), .o_almost_empty(s_ae), .o_almost_full(s_af), .o_count(s_cnt),
    .o_overflow(s_ovf), .o_underflow(s_unf), .o_err_sticky(s_err)
  );

  can_sync_fifo #(.DATA_W(W), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
    .i_sys_clk(clk), .i_reset_n(rst_n), .i_flush(f_flush), .i_wr_en(f_wr),
    .i_fifo_w_data(f_wd), .i_r_en(f_rd), .o_fifo_r_data(f_rdat), .o_empty(f_empty),
    .o_full(f_full), .o_almost_empty(f_ae), .o_almost_full(f_af), .o_count(f_cnt),
    .o_overflow(f_ovf), .o_underflow(f_unf), .o_err_sticky(f_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compact check of the registered-read instance's status outputs.
  task automatic chk_s(input string tag, input int cnt, input bit emp, input bit ful,
                       input bit ae, input bit af, input bit ovf, input bit unf,
                       input logic [1:0] err);
    chk({tag, ".count"}, W'(s_cnt), W'(cnt));
    chk({tag, ".empty"}, W'(s_empty), W'(emp));
    chk({tag, ".full"}, W'(s_full), W'(ful));
    chk({tag, ".ae"}, W'(s_ae), W'(ae));
    chk({tag, ".af"}, W'(s_af), W'(af));
    chk({tag, ".ovf"}, W'(s_ovf), W'(ovf));
    chk({tag, ".unf"}, W'(s_unf), W'(unf));
    chk({tag, ".err"}, W'(s_err), W'(err));
  endtask

  logic [W-1:0] d1, d2, d3, d4, daa;

  initial begin
    d1  = 128'h1;
    d2  = {16{8'h10}};
    d3  = {16{8'hFF}};
    d4  = {16{8'h11}};
    daa = {16{8'hAA}};

    // Reset
    tick();
    tick();
    chk_s("reset", 0, 1, 0, 1, 0, 0, 0, 2'b00);
    chk("reset.rdata", s_rdat, '0);
    chk("reset.f_rdata", f_rdat, '0);
    rst_n = 1'b1;
    tick();

    // Test 1: fill, then overflow
    s_wr = 1; s_wd = d1; tick();
    chk_s("w1", 1, 0, 0, 1, 0, 0, 0, 2'b00);
    s_wd = d2; tick();
    chk_s("w2", 2, 0, 0, 0, 0, 0, 0, 2'b00);
    s_wd = d3; tick();
    chk_s("w3", 3, 0, 0, 0, 1, 0, 0, 2'b00);
    s_wd = d4; tick();
    chk_s("w4", 4, 0, 1, 0, 1, 0, 0, 2'b00);
    s_wd = 128'h99; tick();
    chk_s("w5ovf", 4, 0, 1, 0, 1, 1, 0, 2'b10);
    s_wr = 0; tick();
    chk_s("ovfgone", 4, 0, 1, 0, 1, 0, 0, 2'b10);

    // Test 2: drain in order, then underflow
    s_rd = 1; tick();
    chk("p1.data", s_rdat, d1);
    chk_s("p1", 3, 0, 0, 0, 1, 0, 0, 2'b10);
    tick();
    chk("p2.data", s_rdat, d2);
    tick();
    chk("p3.data", s_rdat, d3);
    tick();
    chk("p4.data", s_rdat, d4);
    chk_s("p4", 0, 1, 0, 1, 0, 0, 0, 2'b10);
    tick();
    chk_s("p5unf", 0, 1, 0, 1, 0, 0, 1, 2'b11);
    chk("p5.hold", s_rdat, d4);
    s_rd = 0; tick();
    chk("unfgone", W'(s_unf), W'(0));

    // Test 3: full with simultaneous push+pop
    s_wr = 1;
    for (int i = 2; i <= 5; i++) begin
      s_wd = W'(i); tick();
    end
    chk("t3.full", W'(s_full), W'(1));
    s_rd = 1; s_wd = daa; tick();
    chk_s("t3.rw", 4, 0, 1, 0, 1, 0, 0, 2'b11);
    chk("t3.rw.data", s_rdat, W'(2));
    s_wr = 0;
    tick(); chk("t3.d3", s_rdat, W'(3));
    tick(); chk("t3.d4", s_rdat, W'(4));
    tick(); chk("t3.d5", s_rdat, W'(5));
    tick(); chk("t3.daa", s_rdat, daa);
    chk("t3.empty", W'(s_empty), W'(1));
    s_rd = 0;

    // Test 4: FWFT instance
    f_wr = 1; f_wd = 128'h5; tick();
    f_wr = 0;
    chk("t4.data", f_rdat, W'(5));
    chk("t4.empty", W'(f_empty), W'(0));
    tick();
    chk("t4.hold", f_rdat, W'(5));
    f_rd = 1; tick();
    f_rd = 0;
    chk("t4.pop.empty", W'(f_empty), W'(1));
    chk("t4.pop.data", f_rdat, W'(0));

    // Test 5: flush with concurrent write
    s_wr = 1;
    for (int i = 0; i < 3; i++) begin
      s_wd = W'(32'h50 + i); tick();
    end
    chk("t5.cnt3", W'(s_cnt), W'(3));
    s_flush = 1; s_wd = 128'h77; tick();
    s_flush = 0; s_wr = 0;
    chk_s("t5.flush", 0, 1, 0, 1, 0, 0, 0, 2'b00);
    chk("t5.rdata", s_rdat, '0);
    s_rd = 1; tick();
    s_rd = 0;
    chk_s("t5.unf", 0, 1, 0, 1, 0, 0, 1, 2'b01);

    // Test 6: order across pointer wrap, then asynchronous reset
    s_flush = 1; tick();
    s_flush = 0;
    s_wr = 1;
    for (int i = 0; i < 3; i++) begin
      s_wd = W'(32'h61 + i); tick();
    end
    s_rd = 1;
    for (int i = 0; i < 3; i++) begin
      s_wd = W'(32'h64 + i); tick();
      chk("t6.rw", s_rdat, W'(32'h61 + i));
      chk("t6.rwcnt", W'(s_cnt), W'(3));
    end
    s_wr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.rd", s_rdat, W'(32'h64 + i));
    end
    chk("t6.empty", W'(s_empty), W'(1));
    chk("t6.err", W'(s_err), W'(0));
    s_rd = 0; s_wr = 1;
    s_wd = 128'h71; tick();
    s_wd = 128'h72; tick();
    s_wd = 128'h73; s_rd = 1; tick();
    chk("t6.pre.data", s_rdat, W'(32'h71));
    chk("t6.pre.cnt", W'(s_cnt), W'(2));
    // Mid-cycle reset: outputs must clear before the next clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_s("t6.async", 0, 1, 0, 1, 0, 0, 0, 2'b00);
    chk("t6.async.data", s_rdat, '0);
    s_wr = 0; s_rd = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6.post.empty", W'(s_empty), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
